// File: rtl/scpad_frontend_rr_arb.sv
// Round-robin N-requester scratchpad frontend: one tagged SRAM request per cycle, responses routed by tag
// into per-requester FIFOs. Request latency 1 cycle; output stage stalls on !sram_req_ready, admission limited by credits.

// Small response FIFO: push visible on pop side the next cycle; push and pop may share a cycle even when full.
module scpad_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             push, pop;

    assign pop_vld = (cnt_q != '0);
    assign pop     = pop_vld & pop_rdy;
    assign push    = push_vld & ((cnt_q != (PTR_W+1)'(DEPTH)) | pop);
    assign pop_dat = pop_vld ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module scpad_frontend_rr_arb #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int RSP_DEPTH = 4,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    output logic                      sram_req_valid,
    input  logic                      sram_req_ready,
    output logic                      sram_req_write,
    output logic [ADDR_W-1:0]         sram_req_addr,
    output logic [DATA_W-1:0]         sram_req_wdata,
    output logic [IDX_W+ID_W-1:0]     sram_req_tag,
    input  logic                      sram_rsp_valid,
    input  logic                      sram_rsp_write,
    input  logic [IDX_W+ID_W-1:0]     sram_rsp_tag,
    input  logic [DATA_W-1:0]         sram_rsp_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ-1:0]        rsp_write,
    output logic [NUM_REQ*ID_W-1:0]   rsp_id,
    output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
    output logic                      bad_tag_err,
    output logic                      busy
);
    localparam int TAG_W = IDX_W + ID_W;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [IDX_W:0] NUM_REQ_C = (IDX_W+1)'(NUM_REQ);

    typedef struct packed {
        logic              write;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              sram_req_valid_q, sram_req_write_q;
    logic [ADDR_W-1:0] sram_req_addr_q;
    logic [DATA_W-1:0] sram_req_wdata_q;
    logic [TAG_W-1:0]  sram_req_tag_q;
    logic              bad_tag_q;
    logic [CNT_W-1:0]  out_cnt_q [NUM_REQ];

    logic [NUM_REQ-1:0] elig, cnt_nz;
    logic               can_load, gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   rsp_idx;
    rsp_t               rsp_in;

    assign can_load = !sram_req_valid_q | sram_req_ready;
    assign rsp_idx  = sram_rsp_tag[TAG_W-1 -: IDX_W];
    assign rsp_in   = '{write: sram_rsp_write, id: sram_rsp_tag[ID_W-1:0], rdata: sram_rsp_rdata};

    // Scan from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(j);
            if (cand >= NUM_REQ_C) cand = cand - NUM_REQ_C;
            if (can_load && !gnt_vld && elig[cand[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q            <= '0;
            sram_req_valid_q <= 1'b0;
            sram_req_write_q <= 1'b0;
            sram_req_addr_q  <= '0;
            sram_req_wdata_q <= '0;
            sram_req_tag_q   <= '0;
            bad_tag_q        <= 1'b0;
        end else begin
            if (can_load) begin
                sram_req_valid_q <= gnt_vld;
                if (gnt_vld) begin
                    ptr_q            <= ptr_d;
                    sram_req_write_q <= req_write[gnt_idx];
                    sram_req_addr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    sram_req_wdata_q <= req_wdata[gnt_idx*DATA_W +: DATA_W];
                    sram_req_tag_q   <= {gnt_idx, req_id[gnt_idx*ID_W +: ID_W]};
                end
            end
            if (sram_rsp_valid && ({1'b0, rsp_idx} >= NUM_REQ_C)) bad_tag_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic inc, dec;
        rsp_t fifo_dat;

        assign inc       = req_ready[i];
        // A stray response with no outstanding request must not wrap the credit counter.
        assign dec       = rsp_valid[i] & rsp_ready[i] & cnt_nz[i];
        assign cnt_nz[i] = (out_cnt_q[i] != '0);
        assign elig[i]   = req_valid[i] & (out_cnt_q[i] < CNT_W'(RSP_DEPTH));

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)           out_cnt_q[i] <= '0;
            else if (inc && !dec) out_cnt_q[i] <= out_cnt_q[i] + CNT_W'(1);
            else if (dec && !inc) out_cnt_q[i] <= out_cnt_q[i] - CNT_W'(1);
        end

        scpad_rsp_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_fifo (
            .clk      (clk),
            .n_rst    (n_rst),
            .push_vld (sram_rsp_valid & (rsp_idx == IDX_W'(i))),
            .push_dat (rsp_in),
            .pop_vld  (rsp_valid[i]),
            .pop_rdy  (rsp_ready[i]),
            .pop_dat  (fifo_dat)
        );

        assign rsp_write[i]                  = fifo_dat.write;
        assign rsp_id[i*ID_W +: ID_W]        = fifo_dat.id;
        assign rsp_rdata[i*DATA_W +: DATA_W] = fifo_dat.rdata;
    end

    assign sram_req_valid = sram_req_valid_q;
    assign sram_req_write = sram_req_write_q;
    assign sram_req_addr  = sram_req_addr_q;
    assign sram_req_wdata = sram_req_wdata_q;
    assign sram_req_tag   = sram_req_tag_q;
    assign bad_tag_err    = bad_tag_q;
    assign busy           = sram_req_valid_q | (|cnt_nz);
endmodule

// File: tb/tb_scpad_frontend_rr_arb.sv
// Directed bench for the round-robin scratchpad frontend: a 2-requester and a 3-requester instance.
module tb_scpad_frontend_rr_arb;
    logic clk, n_rst, n_rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    // 2-requester instance
    logic [1:0]   req_valid_a, req_ready_a, req_write_a;
    logic [31:0]  req_addr_a;
    logic [255:0] req_wdata_a;
    logic [7:0]   req_id_a;
    logic         sram_req_valid_a, sram_req_ready_a, sram_req_write_a;
    logic [15:0]  sram_req_addr_a;
    logic [127:0] sram_req_wdata_a;
    logic [4:0]   sram_req_tag_a;
    logic         sram_rsp_valid_a, sram_rsp_write_a;
    logic [4:0]   sram_rsp_tag_a;
    logic [127:0] sram_rsp_rdata_a;
    logic [1:0]   rsp_valid_a, rsp_ready_a, rsp_write_a;
    logic [7:0]   rsp_id_a;
    logic [255:0] rsp_rdata_a;
    logic         bad_tag_err_a, busy_a;

    // 3-requester instance
    logic [2:0]   req_valid_b, req_ready_b, req_write_b;
    logic [47:0]  req_addr_b;
    logic [383:0] req_wdata_b;
    logic [11:0]  req_id_b;
    logic         sram_req_valid_b, sram_req_ready_b, sram_req_write_b;
    logic [15:0]  sram_req_addr_b;
    logic [127:0] sram_req_wdata_b;
    logic [5:0]   sram_req_tag_b;
    logic         sram_rsp_valid_b, sram_rsp_write_b;
    logic [5:0]   sram_rsp_tag_b;
    logic [127:0] sram_rsp_rdata_b;
    logic [2:0]   rsp_valid_b, rsp_ready_b, rsp_write_b;
    logic [11:0]  rsp_id_b;
    logic [383:0] rsp_rdata_b;
    logic         bad_tag_err_b, busy_b;

    scpad_frontend_rr_arb u_dut_a (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_id(req_id_a),
        .sram_req_valid(sram_req_valid_a), .sram_req_ready(sram_req_ready_a),
        .sram_req_write(sram_req_write_a), .sram_req_addr(sram_req_addr_a),
        .sram_req_wdata(sram_req_wdata_a), .sram_req_tag(sram_req_tag_a),
        .sram_rsp_valid(sram_rsp_valid_a), .sram_rsp_write(sram_rsp_write_a),
        .sram_rsp_tag(sram_rsp_tag_a), .sram_rsp_rdata(sram_rsp_rdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_write(rsp_write_a),
        .rsp_id(rsp_id_a), .rsp_rdata(rsp_rdata_a),
        .bad_tag_err(bad_tag_err_a), .busy(busy_a)
    );

    scpad_frontend_rr_arb #(.NUM_REQ(3)) u_dut_b (
        .clk(clk), .n_rst(n_rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_id(req_id_b),
        .sram_req_valid(sram_req_valid_b), .sram_req_ready(sram_req_ready_b),
        .sram_req_write(sram_req_write_b), .sram_req_addr(sram_req_addr_b),
        .sram_req_wdata(sram_req_wdata_b), .sram_req_tag(sram_req_tag_b),
        .sram_rsp_valid(sram_rsp_valid_b), .sram_rsp_write(sram_rsp_write_b),
        .sram_rsp_tag(sram_rsp_tag_b), .sram_rsp_rdata(sram_rsp_rdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_write(rsp_write_b),
        .rsp_id(rsp_id_b), .rsp_rdata(rsp_rdata_b),
        .bad_tag_err(bad_tag_err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drives one response beat on instance A; entered and left at posedge+1.
    task automatic rsp_send_a(input logic [4:0] tag, input logic [127:0] data, input logic wr);
        sram_rsp_valid_a = 1'b1;
        sram_rsp_tag_a   = tag;
        sram_rsp_rdata_a = data;
        sram_rsp_write_a = wr;
        @(posedge clk); #1;
        sram_rsp_valid_a = 1'b0;
    endtask

    initial begin
        logic [2:0] exp3;
        n_rst = 1'b0; n_rst_b = 1'b0;
        req_valid_a = '0; req_write_a = '0; req_wdata_a = '0;
        req_addr_a = {16'h0200, 16'h0100}; req_id_a = {4'h2, 4'h1};
        sram_req_ready_a = 1'b0; sram_rsp_valid_a = 1'b0; sram_rsp_write_a = 1'b0;
        sram_rsp_tag_a = '0; sram_rsp_rdata_a = '0; rsp_ready_a = '0;
        req_valid_b = '0; req_write_b = '0; req_wdata_b = '0;
        req_addr_b = {16'h0C00, 16'h0B00, 16'h0A00}; req_id_b = {4'h3, 4'h2, 4'h1};
        sram_req_ready_b = 1'b0; sram_rsp_valid_b = 1'b0; sram_rsp_write_b = 1'b0;
        sram_rsp_tag_b = '0; sram_rsp_rdata_b = '0; rsp_ready_b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_vld_a", sram_req_valid_a, 1'b0);
        check("rst_req_tag_a", sram_req_tag_a, 5'h00);
        check("rst_req_rdy_a", req_ready_a, 2'b00);
        check("rst_rsp_vld_a", rsp_valid_a, 2'b00);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_bad_a", bad_tag_err_a, 1'b0);
        check("rst_bad_b", bad_tag_err_b, 1'b0);
        check("rst_rsp_vld_b", rsp_valid_b, 3'b000);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Round-robin alternation with the SRAM always ready
        req_valid_a = 2'b11; sram_req_ready_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rr_gnt", req_ready_a, (c % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_vld", sram_req_valid_a, (c > 0) ? 1'b1 : 1'b0);
            if (c > 0) check("rr_tag", sram_req_tag_a, (c % 2 == 1) ? 5'h01 : 5'h12);
            @(posedge clk); #1;
        end
        req_valid_a = 2'b00;
        #1;
        check("rr_tag_last", sram_req_tag_a, 5'h12);
        check("rr_addr_last", sram_req_addr_a, 16'h0200);
        check("rr_idle_rdy", req_ready_a, 2'b00);
        @(posedge clk); #1;
        check("rr_drain_vld", sram_req_valid_a, 1'b0);
        check("rr_busy_out", busy_a, 1'b1);

        // Response routing by tag
        sram_rsp_valid_a = 1'b1; sram_rsp_tag_a = {1'b1, 4'hA};
        sram_rsp_rdata_a = 128'hDEAD; sram_rsp_write_a = 1'b0;
        @(posedge clk); #1;
        sram_rsp_valid_a = 1'b0;
        #1;
        check("route_vld", rsp_valid_a, 2'b10);
        check("route_id", rsp_id_a[7:4], 4'hA);
        check("route_data", rsp_rdata_a[255:128], 128'hDEAD);
        check("route_wr", rsp_write_a[1], 1'b0);
        rsp_ready_a = 2'b10;
        @(posedge clk); #1;
        rsp_ready_a = 2'b00;
        #1;
        check("route_popped", rsp_valid_a, 2'b00);

        // Per-requester ordering and write-ack flag
        rsp_send_a(5'h01, 128'h11, 1'b0);
        rsp_send_a(5'h01, 128'h22, 1'b0);
        rsp_send_a(5'h12, 128'h33, 1'b1);
        #1;
        check("ord_vld", rsp_valid_a, 2'b11);
        check("ord_first", rsp_rdata_a[127:0], 128'h11);
        check("ord_r1_data", rsp_rdata_a[255:128], 128'h33);
        check("ord_r1_wr", rsp_write_a[1], 1'b1);
        rsp_ready_a = 2'b11;
        @(posedge clk); #1;
        #1;
        check("ord_vld2", rsp_valid_a, 2'b01);
        check("ord_second", rsp_rdata_a[127:0], 128'h22);
        @(posedge clk); #1;
        rsp_ready_a = 2'b00;
        #1;
        check("ord_empty", rsp_valid_a, 2'b00);
        check("ord_not_busy", busy_a, 1'b0);

        // Backpressure: output stage holds while the SRAM stalls
        req_valid_a = 2'b10; sram_req_ready_a = 1'b0;
        #1;
        check("bp_gnt", req_ready_a, 2'b10);
        @(posedge clk); #1;
        req_valid_a = 2'b11; req_addr_a[31:16] = 16'h02FF;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_vld", sram_req_valid_a, 1'b1);
            check("bp_addr", sram_req_addr_a, 16'h0200);
            check("bp_tag", sram_req_tag_a, 5'h12);
            check("bp_rdy", req_ready_a, 2'b00);
            @(posedge clk); #1;
        end
        sram_req_ready_a = 1'b1;
        #1;
        check("bp_release_gnt", req_ready_a, 2'b01);
        @(posedge clk); #1;
        check("bp_next_tag", sram_req_tag_a, 5'h01);
        check("bp_next_addr", sram_req_addr_a, 16'h0100);
        req_valid_a = 2'b00; req_addr_a[31:16] = 16'h0200;
        @(posedge clk); #1;
        rsp_send_a(5'h01, 128'h0, 1'b0);
        rsp_send_a(5'h12, 128'h0, 1'b0);
        rsp_ready_a = 2'b11;
        @(posedge clk); #1;
        rsp_ready_a = 2'b00;
        #1;
        check("bp_drained", busy_a, 1'b0);

        // Credit exhaustion on requester 0
        req_valid_a = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("cred_gnt", req_ready_a, 2'b01);
            @(posedge clk); #1;
        end
        #1;
        check("cred_block", req_ready_a, 2'b00);
        req_valid_a = 2'b11;
        #1;
        check("cred_other", req_ready_a, 2'b10);
        @(posedge clk); #1;
        req_valid_a = 2'b01;
        rsp_send_a(5'h01, 128'hA0, 1'b0);
        #1;
        check("cred_fifo_held", req_ready_a, 2'b00);
        check("cred_rsp_vld", rsp_valid_a[0], 1'b1);
        rsp_ready_a = 2'b01;
        #1;
        check("cred_pop_cycle", req_ready_a, 2'b00);
        @(posedge clk); #1;
        rsp_ready_a = 2'b00;
        #1;
        check("cred_regrant", req_ready_a, 2'b01);
        @(posedge clk); #1;

        // Push, pop and grant on requester 0 in the same cycle
        req_valid_a = 2'b00;
        rsp_send_a(5'h01, 128'hB1, 1'b0);
        sram_rsp_valid_a = 1'b1; sram_rsp_tag_a = 5'h01; sram_rsp_rdata_a = 128'hB2;
        rsp_ready_a = 2'b01; req_valid_a = 2'b01;
        #1;
        check("pp_full_block", req_ready_a, 2'b00);
        check("pp_head_b1", rsp_rdata_a[127:0], 128'hB1);
        @(posedge clk); #1;
        sram_rsp_rdata_a = 128'hB3;
        #1;
        check("pp_gnt", req_ready_a, 2'b01);
        check("pp_head_b2", rsp_rdata_a[127:0], 128'hB2);
        @(posedge clk); #1;
        sram_rsp_valid_a = 1'b0; rsp_ready_a = 2'b00;
        #1;
        check("pp_credit", req_ready_a, 2'b01);
        check("pp_vld", rsp_valid_a[0], 1'b1);
        check("pp_head_b3", rsp_rdata_a[127:0], 128'hB3);
        @(posedge clk); #1;
        #1;
        check("pp_full", req_ready_a, 2'b00);
        req_valid_a = 2'b00;

        // Three requesters: rotation, bad tag, mid-burst reset
        n_rst_b = 1'b1;
        @(posedge clk); #1;
        req_valid_b = 3'b111; sram_req_ready_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            exp3 = 3'b001 << c;
            #1;
            check("b_rr_gnt", req_ready_b, exp3);
            @(posedge clk); #1;
        end
        req_valid_b = 3'b000;
        sram_rsp_valid_b = 1'b1; sram_rsp_tag_b = {2'd3, 4'h7}; sram_rsp_rdata_b = 128'h99;
        @(posedge clk); #1;
        sram_rsp_valid_b = 1'b0;
        #1;
        check("b_bad_set", bad_tag_err_b, 1'b1);
        check("b_bad_dropped", rsp_valid_b, 3'b000);
        check("b_busy", busy_b, 1'b1);
        sram_rsp_valid_b = 1'b1; sram_rsp_tag_b = {2'd2, 4'h5}; sram_rsp_rdata_b = 128'h55;
        @(posedge clk); #1;
        sram_rsp_valid_b = 1'b0;
        #1;
        check("b_route_vld", rsp_valid_b, 3'b100);
        check("b_route_id", rsp_id_b[11:8], 4'h5);
        check("b_route_data", rsp_rdata_b[383:256], 128'h55);
        check("b_bad_sticky", bad_tag_err_b, 1'b1);
        req_valid_b = 3'b111;
        @(posedge clk); #1;
        check("b_burst_vld", sram_req_valid_b, 1'b1);
        n_rst_b = 1'b0; req_valid_b = 3'b000;
        #1;
        check("b_rst_vld", sram_req_valid_b, 1'b0);
        check("b_rst_bad", bad_tag_err_b, 1'b0);
        check("b_rst_rsp", rsp_valid_b, 3'b000);
        check("b_rst_busy", busy_b, 1'b0);
        @(posedge clk); #1;
        n_rst_b = 1'b1;
        sram_rsp_valid_b = 1'b1; sram_rsp_tag_b = {2'd1, 4'h3}; sram_rsp_rdata_b = 128'h77;
        @(posedge clk); #1;
        sram_rsp_valid_b = 1'b0;
        #1;
        check("b_fresh_vld", rsp_valid_b, 3'b010);
        check("b_fresh_data", rsp_rdata_b[255:128], 128'h77);
        check("b_fresh_bad", bad_tag_err_b, 1'b0);
        req_valid_b = 3'b111;
        #1;
        check("b_ptr_reset", req_ready_b, 3'b001);
        req_valid_b = 3'b000;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/scpad_frontend_rr_arb.md
Name: scpad_frontend_rr_arb

Overview:
Parametrised N-requester scratchpad frontend. It replaces the fixed two-port, fixed-priority frontend with a round-robin arbiter. The arbiter issues one SRAM request per cycle through a registered valid/ready stage and tags each request with the requester index. Responses are routed back by tag into per-requester response FIFOs, and credit-based admission means a FIFO never overflows. It sits between the requesting units (vector core, systolic array, future DMA) and the SRAM bank/crossbar path.

Parameters:
NUM_REQ, 2, number of requesting units (>=2)
ADDR_W, 16, request address width
DATA_W, 128, read/write data width
ID_W, 4, requester-local transaction id width
RSP_DEPTH, 4, per-requester response FIFO depth and max outstanding requests (power of 2, >=2)
IDX_W, $clog2(NUM_REQ), derived; requester index width

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_id  in  NUM_REQ*ID_W  packed local ids
sram_req_valid  out  1  registered request to SRAM
sram_req_ready  in  1  SRAM accepts request
sram_req_write  out  1  request type
sram_req_addr  out  ADDR_W  address
sram_req_wdata  out  DATA_W  write data
sram_req_tag  out  IDX_W+ID_W  {requester index, local id}
sram_rsp_valid  in  1  SRAM response valid (no backpressure)
sram_rsp_write  in  1  response is write ack
sram_rsp_tag  in  IDX_W+ID_W  echoed tag
sram_rsp_rdata  in  DATA_W  read data
rsp_valid  out  NUM_REQ  per-requester response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_write  out  NUM_REQ  packed write-ack flags
rsp_id  out  NUM_REQ*ID_W  packed ids
rsp_rdata  out  NUM_REQ*DATA_W  packed read data
bad_tag_err  out  1  sticky: response with index >= NUM_REQ arrived
busy  out  1  any outstanding request or valid output stage

Behaviour:
- Reset: every output 0; RR pointer = 0; all credit counters 0; FIFOs empty; bad_tag_err cleared. Reset mid-transaction discards all in-flight state, and responses arriving after reset are treated as fresh (a valid index is accepted into its FIFO).
- Eligible[i] = req_valid[i] & (outstanding[i] < RSP_DEPTH).
- Stage advance: can_load = !sram_req_valid | sram_req_ready.
- Arbitration (combinational): when can_load, grant the first eligible requester scanning from ptr upward with wrap. At most one req_ready bit high, and only when can_load. req_ready never depends on sram_rsp_*.
- On grant of requester g: the output stage loads {write, addr, wdata, tag={g,id}}, sram_req_valid=1 next cycle, ptr <= (g+1) mod NUM_REQ, outstanding[g]++.
- If can_load and no eligible requester, sram_req_valid <= 0 and ptr is unchanged.
- Output stage holds all fields stable while valid & !sram_req_ready. Request latency is 1 cycle from grant to sram_req_valid.
- Response: on sram_rsp_valid with index k < NUM_REQ, push {write, id, rdata} into FIFO k, and rsp_valid[k] rises the next cycle. A push and pop on the same FIFO in the same cycle are both performed.
- outstanding[k]-- on rsp_valid[k] & rsp_ready[k]. A simultaneous grant and pop on the same k leaves the count unchanged.
- Credits bound FIFO occupancy to RSP_DEPTH, so overflow is impossible.
- Index >= NUM_REQ (non-power-of-2 NUM_REQ): drop the response and set bad_tag_err (sticky until reset); no counter changes.
- FIFO outputs are in order per requester. Cross-requester ordering is not guaranteed.
- busy = sram_req_valid | any outstanding[i] != 0.

Test Plan:
- Reset then idle: all outputs 0; assert req_valid=2'b11 with sram_req_ready=1 -> grants alternate 0,1,0,1; sram_req_tag index sequence 0,1,0,1, one per cycle after 1-cycle latency.
- Backpressure: hold sram_req_ready=0 for 3 cycles with a request loaded -> sram_req_* stable, req_ready=0; release -> next grant on the following cycle.
- Credit exhaustion (RSP_DEPTH=4): requester 0 issues 4 reads with no responses -> 5th req_ready[0]=0 while requester 1 is still granted; one response popped -> requester 0 is granted again.
- Response routing: sram_rsp_valid with tag={1,4'hA}, rdata=128'hDEAD -> next cycle rsp_valid[1]=1, rsp_id[1]=4'hA, rsp_rdata[1]=128'hDEAD; rsp_valid[0]=0.
- Simultaneous push and pop on a full-credit FIFO at same cycle as a new grant to the same requester -> outstanding unchanged, no loss, order preserved.
- NUM_REQ=3: response tag index 3 -> dropped, bad_tag_err=1 and it stays 1; n_rst low mid-burst -> all counters, FIFOs and the flag cleared.
